ern_channel_scheduler: RTL and testbench
========================================

Name: ern_channel_scheduler

Overview:
- Time-shares one ern_detector instance among N error-source channels.
- Each cycle it can: arbitrate round-robin among eligible requesters, issue one sample to the detector, wait the detector latency, and return a tagged result.
- After an ERN on a channel, that channel is masked for a refractory window, modelling the post-error theta burst.
- Sits between the per-channel error generators and the shared detector; its result stream feeds downstream learning/adaptation logic.

Parameters:
- N, 4: number of requesting channels (2..16).
- DET_LAT, 1: cycles from the detector's error_valid cycle to the cycle in which ern_pulse is valid (1..7).
- REFRACT, 8: cycles a channel stays ineligible after an ERN result (0 disables).
- CW, $clog2(N): channel-index width.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req_valid, input, N: per-channel sample valid.
- req_error, input, N*16: per-channel signed error; channel i occupies bits [16i+15:16i].
- req_ready, output, N: per-channel accept, one-hot or zero.
- det_error_raw, output, 16: signed sample to the detector.
- det_error_valid, output, 1: detector strobe.
- det_ern_pulse, input, 1: detector result.
- res_valid, output, 1: result valid.
- res_ready, input, 1: result accept.
- res_chan, output, CW: channel of the result.
- res_ern, output, 1: ERN flag of the result.
- res_error, output, 16: echoed sample.
- refract_active, output, N: channel is in its refractory window.
- ern_count, output, 16: total ERN results, saturating.
- busy, output, 1: state != IDLE.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Refractory counters 0.
  - last_grant = N-1, so channel 0 has first priority.
- Eligibility: eligible[i] = req_valid[i] & ~refract_active[i].
- IDLE:
  - If any channel is eligible, grant g = first eligible index searching upward from last_grant+1, with wrap-around.
  - req_ready[g] = 1 combinationally in this cycle only; the handshake completes here.
  - Latch req_error[g] and g; last_grant <= g; next state ISSUE.
  - If none are eligible, stay in IDLE with req_ready = 0.
- ISSUE:
  - det_error_valid = 1 for exactly this cycle; det_error_raw = latched sample, held until the next issue.
  - Load wait counter = DET_LAT; next state WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle that is DET_LAT cycles after the ISSUE cycle: capture det_ern_pulse into res_ern, go to REPORT.
  - If the captured value is 1, load refract counter[chan] = REFRACT and increment ern_count, saturating at 16'hFFFF.
- REPORT:
  - res_valid = 1; res_chan, res_ern and res_error are stable until res_ready.
  - On res_valid & res_ready, go to IDLE.
  - No new grant is issued in the handshake cycle. Minimum period is 3+DET_LAT cycles per sample.
- Refractory:
  - Each nonzero counter decrements every cycle, in every state.
  - refract_active[i] = (counter[i] != 0).
  - A load in the same cycle as a decrement wins, i.e. the counter is set to REFRACT.
- Input stability: req_valid/req_error may change freely when not granted. Once req_valid is asserted, a requester holds it until req_ready.
- Simultaneous events: a request arriving while busy waits; no queueing inside the block.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs 0; the in-flight result is discarded.
  - Refractory counters clear; last_grant returns to N-1.

Decomposition:
- Package ern_pkg:
  - ERR_W = 16.
  - State enum {IDLE, ISSUE, WAIT, REPORT}.
  - ERN count width and its saturation constant.
- Sub-module rr_arbiter (N, CW):
  - Inputs: eligible vector, last_grant.
  - Outputs: grant index and any_grant, purely combinational.
  - Reusable for other shared cortex-model resources.

Test Plan:
1. ch0 req_error=150, detector THRESH=100 -> det_error_valid high 1 cycle carrying 150; res_chan=0, res_ern=1, ern_count=1; refract_active[0] high 8 cycles.
2. All 4 channels valid with error 10, res_ready=1 -> grant order 0,1,2,3,0; every res_ern=0; consecutive req_ready pulses spaced 4 cycles apart (DET_LAT=1).
3. ch2 error -101 -> res_ern=1. ch2 error -100 -> res_ern=0. error 16'sh8000 (most negative) -> res_ern=1.
4. res_ready held 0 for 5 cycles during REPORT -> res_* stable, req_ready stays 0, busy=1; release -> IDLE on the next cycle.
5. ch1 ERN with REFRACT=8 and ch1, ch2 re-requesting -> ch2 served, ch1 masked; ch1 granted only after refract_active[1] falls.
6. rst_n low during WAIT -> all outputs 0 immediately; after release with ch3 and ch0 valid -> ch0 granted first.

Source files
------------

// File: rtl/ern_channel_scheduler_pkg.sv
// Shared types and constants for the ERN channel scheduler and its
// round-robin arbiter.
package ern_pkg;

   localparam int ERR_W = 16;
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      REPORT
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ern_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible index
// searching upward from last_grant+1 with wrap-around.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int CW = $clog2(N)
) (
   input  logic [N-1:0]  i_eligible,
   input  logic [CW-1:0] i_last_grant,
   output logic [CW-1:0] o_grant,
   output logic          o_any_grant
);

   // One extra bit so last_grant + k never overflows before the wrap.
   logic [CW:0] w_idx;

   always_comb begin
      o_grant     = '0;
      o_any_grant = 1'b0;
      w_idx       = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = {1'b0, i_last_grant} + (CW+1)'(k);
         if (w_idx >= (CW+1)'(N)) begin
            w_idx = w_idx - (CW+1)'(N);
         end
         if (!o_any_grant && i_eligible[w_idx[CW-1:0]]) begin
            o_any_grant = 1'b1;
            o_grant     = w_idx[CW-1:0];
         end
      end
   end

endmodule

// File: rtl/ern_channel_scheduler.sv
// Time-shares one ERN detector among N error channels, with a per-channel
// refractory mask after every ERN result.
//
// state  | meaning
// IDLE   | arbitrate; grant one eligible channel and latch its sample
// ISSUE  | strobe the latched sample into the detector
// WAIT   | count down detector latency, capture det_ern_pulse at terminal count
// REPORT | hold the tagged result until res_ready
module ern_channel_scheduler
   import ern_pkg::*;
#(
   parameter int N       = 4,
   parameter int DET_LAT = 1,
   parameter int REFRACT = 8,
   parameter int CW      = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       req_valid,
   input  logic [N*ERR_W-1:0] req_error,
   output logic [N-1:0]       req_ready,
   output logic [ERR_W-1:0]   det_error_raw,
   output logic               det_error_valid,
   input  logic               det_ern_pulse,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [CW-1:0]      res_chan,
   output logic               res_ern,
   output logic [ERR_W-1:0]   res_error,
   output logic [N-1:0]       refract_active,
   output logic [CNT_W-1:0]   ern_count,
   output logic               busy
);

   localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

   state_t           r_state;
   logic [CW-1:0]    r_last;
   logic [CW-1:0]    r_chan;
   logic [ERR_W-1:0] r_sample;
   logic [2:0]       r_wait;
   logic             r_det_valid;
   logic             r_res_valid;
   logic             r_res_ern;
   logic [CNT_W-1:0] r_ern_count;
   logic [RW-1:0]    r_refract [N];

   logic [N-1:0]     w_refract_active;
   logic [N-1:0]     w_eligible;
   logic [CW-1:0]    w_grant;
   logic             w_any_grant;
   logic             w_grant_now;
   logic             w_capture;
   logic             w_ern_hit;
   logic [ERR_W-1:0] w_sel_error;

   always_comb begin
      w_refract_active = '0;
      for (int i = 0; i < N; i++) begin
         w_refract_active[i] = (r_refract[i] != '0);
      end
   end

   assign w_eligible = req_valid & ~w_refract_active;

   rr_arbiter #(
      .N  (N),
      .CW (CW)
   ) u_arb (
      .i_eligible   (w_eligible),
      .i_last_grant (r_last),
      .o_grant      (w_grant),
      .o_any_grant  (w_any_grant)
   );

   // req_ready is combinational, so it is gated by reset to stay low there.
   assign w_grant_now = rst_n && (r_state == IDLE) && w_any_grant;
   assign w_capture   = (r_state == WAIT) && (r_wait == 3'd1);
   assign w_ern_hit   = w_capture && det_ern_pulse;

   always_comb begin
      req_ready = '0;
      if (w_grant_now) begin
         req_ready[w_grant] = 1'b1;
      end
   end

   always_comb begin
      w_sel_error = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant == CW'(i)) begin
            w_sel_error = req_error[i*ERR_W +: ERR_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_last      <= CW'(N - 1);
         r_chan      <= '0;
         r_sample    <= '0;
         r_wait      <= '0;
         r_det_valid <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_ern   <= 1'b0;
         r_ern_count <= '0;
      end else begin
         r_det_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_grant) begin
                  r_sample    <= w_sel_error;
                  r_chan      <= w_grant;
                  r_last      <= w_grant;
                  r_det_valid <= 1'b1;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               r_wait  <= 3'(DET_LAT);
               r_state <= WAIT;
            end
            WAIT: begin
               if (w_capture) begin
                  r_res_ern   <= det_ern_pulse;
                  r_res_valid <= 1'b1;
                  if (det_ern_pulse) begin
                     r_ern_count <= sat_inc(r_ern_count);
                  end
                  r_state <= REPORT;
               end else begin
                  r_wait <= r_wait - 3'd1;
               end
            end
            REPORT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A fresh ERN load takes priority over the ongoing decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            r_refract[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_ern_hit && (r_chan == CW'(i))) begin
               r_refract[i] <= RW'(REFRACT);
            end else if (r_refract[i] != '0) begin
               r_refract[i] <= r_refract[i] - RW'(1);
            end
         end
      end
   end

   assign det_error_raw   = r_sample;
   assign det_error_valid = r_det_valid;
   assign res_valid       = r_res_valid;
   assign res_chan        = r_chan;
   assign res_ern         = r_res_ern;
   assign res_error       = r_sample;
   assign refract_active  = w_refract_active;
   assign ern_count       = r_ern_count;
   assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_ern_channel_scheduler.sv
// Directed bench for ern_channel_scheduler with a threshold-100 detector
// model (|error| > 100 flags an ERN, one cycle after the strobe).
module tb_ern_channel_scheduler;

   localparam int N       = 4;
   localparam int DET_LAT = 1;
   localparam int REFRACT = 8;
   localparam int CW      = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*16-1:0] req_error = '0;
   logic [N-1:0]    req_ready;
   logic [15:0]     det_error_raw;
   logic            det_error_valid;
   logic            det_ern_pulse = 1'b0;
   logic            res_valid;
   logic            res_ready = 1'b1;
   logic [CW-1:0]   res_chan;
   logic            res_ern;
   logic [15:0]     res_error;
   logic [N-1:0]    refract_active;
   logic [15:0]     ern_count;
   logic            busy;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int cyc      = 0;

   ern_channel_scheduler #(
      .N       (N),
      .DET_LAT (DET_LAT),
      .REFRACT (REFRACT),
      .CW      (CW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_error       (req_error),
      .req_ready       (req_ready),
      .det_error_raw   (det_error_raw),
      .det_error_valid (det_error_valid),
      .det_ern_pulse   (det_ern_pulse),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_chan        (res_chan),
      .res_ern         (res_ern),
      .res_error       (res_error),
      .refract_active  (refract_active),
      .ern_count       (ern_count),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      det_ern_pulse <= det_error_valid &&
                       (($signed(det_error_raw) > 16'sd100) ||
                        ($signed(det_error_raw) < -16'sd100));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      int          ch;
      logic [15:0] err;
      logic        ern;
      logic [15:0] cnt;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int ch, input logic v, input logic [15:0] e);
      req_valid[ch]         = v;
      req_error[ch*16 +: 16] = e;
   endtask

   task automatic wait_grant(input int ch, output int at);
      int n;
      n = 0;
      #1;
      while (req_ready[ch] !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk($sformatf("grant_ch%0d", ch), 32'(req_ready), 32'(1 << ch));
      at = cyc;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      chk("idle", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      step();
      rst_n     = 1'b0;
      req_valid = '0;
      res_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Returns in the REPORT cycle with res_ready high.
   task automatic run_one(input int ch, input logic [15:0] err, input logic exp_ern,
                          input logic [15:0] exp_cnt);
      int t;
      set_req(ch, 1'b1, err);
      wait_grant(ch, t);
      step();
      req_valid[ch] = 1'b0;
      chk("det_valid_issue", 32'(det_error_valid), 32'd1);
      chk("det_raw", 32'(det_error_raw), 32'(err));
      step();
      chk("det_valid_one_cycle", 32'(det_error_valid), 32'd0);
      step();
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_chan", 32'(res_chan), 32'(ch));
      chk("res_ern", 32'(res_ern), 32'(exp_ern));
      chk("res_error", 32'(res_error), 32'(err));
      chk("ern_count", 32'(ern_count), 32'(exp_cnt));
   endtask

   initial begin
      int t, t2, tr, prev, n;

      vt[0] = '{0, 16'h0096, 1'b1, 16'd1};
      vt[1] = '{2, 16'hFF9B, 1'b1, 16'd2};
      vt[2] = '{2, 16'hFF9C, 1'b0, 16'd2};
      vt[3] = '{3, 16'h8000, 1'b1, 16'd3};
      vt[4] = '{1, 16'h0064, 1'b0, 16'd3};
      vt[5] = '{1, 16'h0065, 1'b1, 16'd4};
      vt[6] = '{3, 16'h0000, 1'b0, 16'd4};
      vt[7] = '{0, 16'h7FFF, 1'b1, 16'd5};

      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_det_valid", 32'(det_error_valid), 32'd0);
      chk("rst_det_raw", 32'(det_error_raw), 32'd0);
      chk("rst_ern_count", 32'(ern_count), 32'd0);
      chk("rst_refract", 32'(refract_active), 32'd0);
      rst_n = 1'b1;

      // Single-channel vectors; vector 0 also measures the refractory window.
      for (int i = 0; i < 8; i++) begin
         run_one(vt[i].ch, vt[i].err, vt[i].ern, vt[i].cnt);
         if (i == 0) begin
            n = 0;
            while (refract_active[0] === 1'b1 && n < 20) begin
               n++;
               step();
            end
            chk("refract_len_ch0", 32'(n), 32'(REFRACT));
         end
      end
      wait_idle();

      // Round robin with all channels requesting.
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'd10);
      prev = 0;
      for (int g = 0; g < 5; g++) begin
         wait_grant(g % N, t);
         if (g > 0) chk("rr_spacing", 32'(t - prev), 32'd4);
         prev = t;
         step();
         step();
         step();
         chk("rr_res_chan", 32'(res_chan), 32'(g % N));
         chk("rr_res_ern", 32'(res_ern), 32'd0);
      end
      req_valid = '0;
      wait_idle();

      // Back-pressure on the result port.
      do_reset();
      res_ready = 1'b0;
      set_req(1, 1'b1, 16'h0005);
      wait_grant(1, t);
      step();
      req_valid = 4'b0001;
      req_error[15:0] = 16'h0007;
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         chk("stall_res_valid", 32'(res_valid), 32'd1);
         chk("stall_res_chan", 32'(res_chan), 32'd1);
         chk("stall_res_error", 32'(res_error), 32'h5);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_busy", 32'(busy), 32'd1);
         step();
      end
      res_ready = 1'b1;
      step();
      chk("release_busy", 32'(busy), 32'd0);
      chk("release_res_valid", 32'(res_valid), 32'd0);
      chk("release_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      wait_idle();

      // Refractory masking: ch1 ERN, then ch1 and ch2 both re-request.
      do_reset();
      run_one(1, 16'd200, 1'b1, 16'd1);
      tr = cyc;
      set_req(1, 1'b1, 16'd10);
      set_req(2, 1'b1, 16'd10);
      wait_grant(2, t);
      chk("refr_ch2_next", 32'(t - tr), 32'd1);
      step();
      req_valid[2] = 1'b0;
      step();
      step();
      chk("refr_ch2_res", 32'(res_chan), 32'd2);
      chk("refr_ch2_ern", 32'(res_ern), 32'd0);
      chk("refr_ch1_masked", 32'(refract_active[1]), 32'd1);
      wait_grant(1, t2);
      chk("refr_ch1_delay", 32'(t2 - tr), 32'(REFRACT));
      chk("refr_ch1_clear", 32'(refract_active[1]), 32'd0);
      step();
      req_valid[1] = 1'b0;
      wait_idle();

      // Reset while a sample is in flight.
      do_reset();
      run_one(3, 16'd300, 1'b1, 16'd1);
      set_req(0, 1'b1, 16'd150);
      wait_grant(0, t);
      step();
      req_valid[0] = 1'b0;
      step();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      req_valid = 4'b1001;
      #1;
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_det_valid", 32'(det_error_valid), 32'd0);
      chk("mid_rst_det_raw", 32'(det_error_raw), 32'd0);
      chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_res_ern", 32'(res_ern), 32'd0);
      chk("mid_rst_res_error", 32'(res_error), 32'd0);
      chk("mid_rst_refract", 32'(refract_active), 32'd0);
      chk("mid_rst_ern_count", 32'(ern_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rst_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
